// File: rtl/network_interface_tx.sv
// Packetiser for a router local port: emits a header flit, then len+1 body flits from a payload FIFO.
// Flits are registered (one cycle after the decision); local_full_i stalls, an empty FIFO inserts idle cycles.

module network_interface_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pop is gated on the registered count, so a word pushed this cycle is never read through.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module network_interface_tx #(
  parameter int ROUTER_ID  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid_i,
  output logic        pkt_ready_o,
  input  logic [3:0]  pkt_dest_i,
  input  logic [2:0]  pkt_len_i,
  input  logic        pay_valid_i,
  output logic        pay_ready_o,
  input  logic [14:0] pay_data_i,
  input  logic        local_full_i,
  output logic [16:0] local_data_o,
  output logic        busy_o,
  output logic        pkt_sent_o
);
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  localparam logic [3:0] SRC_ID = 4'(ROUTER_ID);

  state_t      state_q, state_d;
  logic [3:0]  dest_q, dest_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [16:0] flit_q, flit_d;
  logic        sent_q, sent_d;

  logic        fifo_pop;
  logic [14:0] fifo_data;
  logic        fifo_full;
  logic        fifo_empty;

  network_interface_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (15)
  ) u_pay_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pay_valid_i),
    .data_i  (pay_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pay_ready_o  = !fifo_full;
  assign pkt_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign local_data_o = flit_q;
  assign pkt_sent_o   = sent_q;

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    flit_d   = '0;
    sent_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_valid_i) begin
          dest_d  = pkt_dest_i;
          len_d   = pkt_len_i;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (!local_full_i) begin
          flit_d  = {1'b1, 1'b1, dest_q, SRC_ID, len_q, 4'b0000};
          bcnt_d  = len_q;
          state_d = BODY;
        end
      end
      BODY: begin
        if (!local_full_i && !fifo_empty) begin
          fifo_pop = 1'b1;
          flit_d   = {1'b1, 1'b0, fifo_data};
          // pkt_sent_o is registered alongside the flit so it lines up with the last body flit.
          if (bcnt_q == 3'd0) begin
            sent_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      bcnt_q  <= '0;
      flit_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      flit_q  <= flit_d;
      sent_q  <= sent_d;
    end
  end
endmodule

// File: tb/tb_network_interface_tx.sv
// Bench for network_interface_tx: a queue of expected {pkt_sent, flit} pairs is checked by a monitor,
// plus cycle-exact direct checks for stalls, back-to-back packets, FIFO full and mid-packet reset.

module tb_network_interface_tx;
  logic        clk;
  logic        rst;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [3:0]  pkt_dest_i;
  logic [2:0]  pkt_len_i;
  logic        pay_valid_i;
  logic        pay_ready_o;
  logic [14:0] pay_data_i;
  logic        local_full_i;
  logic [16:0] local_data_o;
  logic        busy_o;
  logic        pkt_sent_o;

  int vectors;
  int miscompares;
  logic [17:0] exp_q[$];

  network_interface_tx #(
    .ROUTER_ID  (0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid_i  (pkt_valid_i),
    .pkt_ready_o  (pkt_ready_o),
    .pkt_dest_i   (pkt_dest_i),
    .pkt_len_i    (pkt_len_i),
    .pay_valid_i  (pay_valid_i),
    .pay_ready_o  (pay_ready_o),
    .pay_data_i   (pay_data_i),
    .local_full_i (local_full_i),
    .local_data_o (local_data_o),
    .busy_o       (busy_o),
    .pkt_sent_o   (pkt_sent_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_flit(input logic sent, input logic [16:0] flit);
    exp_q.push_back({sent, flit});
  endtask

  task automatic push_words(input logic [14:0] w0, input logic [14:0] w1, input int n);
    for (int i = 0; i < n; i++) begin
      pay_valid_i = 1'b1;
      pay_data_i  = (i == 0) ? w0 : w1 + 15'(i - 1);
      tick();
    end
    pay_valid_i = 1'b0;
  endtask

  task automatic accept_pkt(input logic [3:0] dest, input logic [2:0] len);
    pkt_valid_i = 1'b1;
    pkt_dest_i  = dest;
    pkt_len_i   = len;
    check("pkt_ready_before_accept", 32'(pkt_ready_o), 32'd1);
    tick();
    pkt_valid_i = 1'b0;
  endtask

  task automatic wait_sent(input string name, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pkt_sent_o) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic sample(input string name, input logic [16:0] flit, input logic sent);
    @(negedge clk);
    check(name, {14'd0, sent, flit}, {14'd0, pkt_sent_o, local_data_o});
  endtask

  // Every valid flit must match the head of the expected queue, including its pkt_sent alignment.
  always @(negedge clk) begin
    if (rst) begin
      if (local_data_o[16]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", {14'd0, pkt_sent_o, local_data_o}, 32'd0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          check("flit_order", {14'd0, pkt_sent_o, local_data_o}, {14'd0, e});
        end
      end else if (pkt_sent_o) begin
        check("sent_without_flit", 32'(pkt_sent_o), 32'd0);
      end
    end
  end

  initial begin
    int bad;
    int pulses;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    pkt_valid_i  = 1'b0;
    pkt_dest_i   = '0;
    pkt_len_i    = '0;
    pay_valid_i  = 1'b0;
    pay_data_i   = '0;
    local_full_i = 1'b0;

    #12;
    check("rst_local_data", 32'(local_data_o), 32'd0);
    check("rst_pkt_sent", 32'(pkt_sent_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_pkt_ready", 32'(pkt_ready_o), 32'd1);
    check("rst_pay_ready", 32'(pay_ready_o), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // Prefilled basic packet, flits on consecutive cycles
    push_words(15'h1111, 15'h2222, 2);
    expect_flit(1'b0, 17'h19810);
    expect_flit(1'b0, 17'h11111);
    expect_flit(1'b1, 17'h12222);
    accept_pkt(4'd3, 3'd1);
    @(negedge clk);
    check("t1_head_busy", 32'(busy_o), 32'd1);
    check("t1_head_not_ready", 32'(pkt_ready_o), 32'd0);
    check("t1_head_idle_out", 32'(local_data_o), 32'd0);
    tick(); sample("t1_header", 17'h19810, 1'b0);
    tick(); sample("t1_body0", 17'h11111, 1'b0);
    tick(); sample("t1_body1", 17'h12222, 1'b1);
    tick();
    @(negedge clk);
    check("t1_done_busy", 32'(busy_o), 32'd0);
    check("t1_done_out", 32'(local_data_o), 32'd0);

    // Header stalled three cycles by local_full_i
    push_words(15'h0ABC, 15'h0, 1);
    expect_flit(1'b0, 17'h1A800);
    expect_flit(1'b1, 17'h10ABC);
    local_full_i = 1'b1;
    accept_pkt(4'd5, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sample("t2_stall_zero", 17'h0, 1'b0);
    end
    local_full_i = 1'b0;
    tick(); sample("t2_header", 17'h1A800, 1'b0);
    tick(); sample("t2_body", 17'h10ABC, 1'b1);
    tick(); tick();

    // Long packet fed one word every other cycle
    expect_flit(1'b0, 17'h1C870);
    for (int i = 0; i < 8; i++) expect_flit(i == 7, 17'h11000 + 17'(i));
    accept_pkt(4'd9, 3'd7);
    bad = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pay_valid_i = 1'b1;
      pay_data_i  = 15'h1000 + 15'(i);
      tick();
      pay_valid_i = 1'b0;
      @(negedge clk);
      if (pkt_sent_o) pulses++; else if (!busy_o) bad++;
      tick();
      @(negedge clk);
      if (pkt_sent_o) pulses++; else if (!busy_o) bad++;
    end
    if (pulses == 0) wait_sent("t3_sent_seen", 10);
    else check("t3_sent_once", 32'(pulses), 32'd1);
    check("t3_busy_throughout", 32'(bad), 32'd0);
    tick(); tick();

    // FIFO full: fifth word held off until the packet drains a word
    for (int i = 0; i < 4; i++) begin
      pay_valid_i = 1'b1;
      pay_data_i  = 15'h0A01 + 15'(i);
      check("t4_ready_not_full", 32'(pay_ready_o), 32'd1);
      tick();
    end
    pay_data_i = 15'h0A05;
    @(negedge clk);
    check("t4_ready_full", 32'(pay_ready_o), 32'd0);
    tick();
    @(negedge clk);
    check("t4_ready_full_hold", 32'(pay_ready_o), 32'd0);
    expect_flit(1'b0, 17'h19040);
    for (int i = 0; i < 5; i++) expect_flit(i == 4, 17'h10A01 + 17'(i));
    tick();
    accept_pkt(4'd2, 3'd4);
    check("t4_head_still_full", 32'(pay_ready_o), 32'd0);
    bad = 1;
    for (int i = 0; i < 10; i++) begin
      if (pay_ready_o) begin
        bad = 0;
        tick();
        break;
      end
      tick();
    end
    pay_valid_i = 1'b0;
    check("t4_fifth_accepted", 32'(bad), 32'd0);
    wait_sent("t4_sent_seen", 20);
    tick(); tick();

    // Back-to-back len=0 packets with the descriptor held valid
    push_words(15'h0111, 15'h0222, 2);
    expect_flit(1'b0, 17'h18800);
    expect_flit(1'b1, 17'h10111);
    expect_flit(1'b0, 17'h18800);
    expect_flit(1'b1, 17'h10222);
    pkt_valid_i = 1'b1;
    pkt_dest_i  = 4'd1;
    pkt_len_i   = 3'd0;
    tick(); sample("t5_head0", 17'h0, 1'b0);
    tick(); sample("t5_header0", 17'h18800, 1'b0);
    tick(); sample("t5_body0", 17'h10111, 1'b1);
    check("t5_ready_on_sent", 32'(pkt_ready_o), 32'd1);
    tick();
    pkt_valid_i = 1'b0;
    sample("t5_gap", 17'h0, 1'b0);
    tick(); sample("t5_header1", 17'h18800, 1'b0);
    tick(); sample("t5_body1", 17'h10222, 1'b1);
    tick(); tick();

    // Reset after two of four body flits
    push_words(15'h0C01, 15'h0C02, 4);
    expect_flit(1'b0, 17'h1A030);
    for (int i = 0; i < 4; i++) expect_flit(i == 3, 17'h10C01 + 17'(i));
    accept_pkt(4'd4, 3'd3);
    tick(); sample("t6_header", 17'h1A030, 1'b0);
    tick(); sample("t6_body0", 17'h10C01, 1'b0);
    tick(); sample("t6_body1", 17'h10C02, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_out", 32'(local_data_o), 32'd0);
    check("t6_rst_sent", 32'(pkt_sent_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_pkt_ready", 32'(pkt_ready_o), 32'd1);
    check("t6_rst_pay_ready", 32'(pay_ready_o), 32'd1);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    // FIFO must be empty: the next packet stalls in BODY until a fresh word arrives.
    expect_flit(1'b0, 17'h1B000);
    expect_flit(1'b1, 17'h10D0D);
    accept_pkt(4'd6, 3'd0);
    tick(); sample("t6_post_header", 17'h1B000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sample("t6_empty_stall", 17'h0, 1'b0);
    end
    check("t6_stall_busy", 32'(busy_o), 32'd1);
    push_words(15'h0D0D, 15'h0, 1);
    sample("t6_body_after_push", 17'h0, 1'b0);
    tick(); sample("t6_fresh_body", 17'h10D0D, 1'b1);
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule
